// File: rtl/vscale_src_b_sched.sv
// Operand-B path scheduler: the pipeline DX stage owns src_b by default, and one aux
// requester gets bounded bursts (optional stall counter under SRC_B_SCHED_PERF_EN).
module vscale_src_b_sched #(
    parameter int BURST_W         = 4,
    parameter int STARVE_MAX      = 8,
    parameter int SRC_B_SEL_WIDTH = 2,
    parameter int XPR_LEN         = 32
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       p_req,
    input  logic [SRC_B_SEL_WIDTH-1:0] p_src_b_sel,
    input  logic [XPR_LEN-1:0]         p_imm,
    output logic                       p_gnt,
    output logic                       p_stall,
    input  logic                       a_req,
    input  logic [BURST_W-1:0]         a_len,
    input  logic [SRC_B_SEL_WIDTH-1:0] a_src_b_sel,
    input  logic [XPR_LEN-1:0]         a_imm,
    output logic                       a_gnt,
    output logic                       a_done,
    output logic [SRC_B_SEL_WIDTH-1:0] src_b_sel,
    output logic [XPR_LEN-1:0]         imm,
    output logic [15:0]                perf_stall
);

    localparam int STARVE_W = $clog2(STARVE_MAX + 1);
    localparam logic [STARVE_W-1:0] STARVE_CAP = STARVE_W'(STARVE_MAX);

    typedef enum logic {S_PIPE, S_AUX} state_t;

    state_t              state;
    state_t              next_state;
    logic [BURST_W-1:0]  cnt;
    logic [STARVE_W-1:0] starve;

    // cnt holds the remaining burst cycles minus one; starve counts contended cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= S_PIPE;
            cnt    <= '0;
            starve <= '0;
        end else begin
            state <= next_state;
            if (state == S_PIPE) begin
                if (next_state == S_AUX) begin
                    cnt    <= a_len;
                    starve <= '0;
                end else if (!a_req) begin
                    starve <= '0;
                end else if (starve != STARVE_CAP) begin
                    starve <= starve + STARVE_W'(1);
                end
            end else if (cnt != '0) begin
                cnt <= cnt - BURST_W'(1);
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_PIPE: if (a_req && (!p_req || starve == STARVE_CAP)) next_state = S_AUX;
            S_AUX:  if (cnt == '0) next_state = S_PIPE;
        endcase
    end

    // The only input-to-output paths are the operand pass-through and p_gnt/p_stall gating.
    always_comb begin
        src_b_sel = p_src_b_sel;
        imm       = p_imm;
        p_gnt     = p_req;
        p_stall   = 1'b0;
        a_gnt     = 1'b0;
        a_done    = 1'b0;
        if (state == S_AUX) begin
            src_b_sel = a_src_b_sel;
            imm       = a_imm;
            p_gnt     = 1'b0;
            p_stall   = p_req;
            a_gnt     = 1'b1;
            a_done    = (cnt == '0);
        end
    end

`ifdef SRC_B_SCHED_PERF_EN
    logic [15:0] stall_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
        end else if (p_stall && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    assign perf_stall = stall_cnt;
`else
    assign perf_stall = 16'h0;
`endif

endmodule
